// File: rtl/sram_fifo_ctrl_if.sv
// User-side request/acknowledge handshake of the SRAM-backed FIFO controller.
interface sram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_data, rd_req,
        input  wr_ack, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output wr_ack, rd_data, rd_valid
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller storing its words in an external asynchronous single-port
// SRAM. Reads and writes are serialised through a strobe sequencer; when both
// sides are waiting, service alternates between them.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for an eligible request, arbitration happens here
// WR_SETUP  | address/data driven, wr_ack pulsed, wr_n still high
// WR_STROBE | wr_n low for WR_CYC cycles
// WR_HOLD   | wr_n high, address/data still driven, then wp/count advance
// RD_SETUP  | address driven, bus released, rd_n low
// RD_STROBE | rd_n low for RD_CYC cycles, data sampled on the last edge
// RD_HOLD   | rd_n high, rd_valid pulsed, then rp/count advance
module sram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int WR_CYC = 2,
    parameter int RD_CYC = 2,
    parameter int AF_LVL = (2 ** ADDR_W) - 4,
    parameter int AE_LVL = 4
) (
    input  logic                clk,
    input  logic                rst,
    sram_fifo_ctrl_if.slave     bus,
    input  logic                clr_err,
    output logic                nfull,
    output logic                nempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_data,
    output logic                sram_rd_n,
    output logic                sram_wr_n
);

    localparam int CYC_MAX = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int CW      = $clog2(CYC_MAX) + 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
    localparam logic [CW-1:0]   WR_LOAD = CW'(WR_CYC - 1);
    localparam logic [CW-1:0]   RD_LOAD = CW'(RD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_SETUP  = 3'd4,
        RD_STROBE = 3'd5,
        RD_HOLD   = 3'd6
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       strb_cnt;
    logic [ADDR_W-1:0]   wp, rp;
    logic [DATA_W-1:0]   wdat;
    logic [DATA_W-1:0]   rd_data_q;
    logic                last_wr;
    logic                wr_ok, rd_ok;
    logic                accept_wr, accept_rd;
    logic                bus_oe;
    logic                wr_ack_c, rd_valid_c;
    logic                inc, dec;
    logic [ADDR_W:0]     count_nxt;

    assign wr_ok = bus.wr_req && nfull;
    assign rd_ok = bus.rd_req && nempty;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a tie goes to whichever type was not served last.
    always_comb begin
        state_nxt = state;
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ok && (!rd_ok || !last_wr)) begin
                    state_nxt = WR_SETUP;
                    accept_wr = 1'b1;
                end else if (rd_ok) begin
                    state_nxt = RD_SETUP;
                    accept_rd = 1'b1;
                end
            end
            WR_SETUP:  state_nxt = WR_STROBE;
            WR_STROBE: if (strb_cnt == '0) state_nxt = WR_HOLD;
            WR_HOLD:   state_nxt = IDLE;
            RD_SETUP:  state_nxt = RD_STROBE;
            RD_STROBE: if (strb_cnt == '0) state_nxt = RD_HOLD;
            RD_HOLD:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode; strobes come straight from the state flops.
    always_comb begin
        wr_ack_c   = (state == WR_SETUP);
        rd_valid_c = (state == RD_HOLD);
        sram_wr_n  = (state != WR_STROBE);
        sram_rd_n  = !((state == RD_SETUP) || (state == RD_STROBE));
        bus_oe     = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
        inc        = (state == WR_HOLD);
        dec        = (state == RD_HOLD);
    end

    assign bus.wr_ack   = wr_ack_c;
    assign bus.rd_valid = rd_valid_c;
    assign bus.rd_data  = rd_data_q;
    assign sram_data    = bus_oe ? wdat : {DATA_W{1'bz}};

    // Strobe length timer: loaded in SETUP, terminal count at zero.
    always_ff @(posedge clk) begin
        if (rst)                      strb_cnt <= '0;
        else if (state == WR_SETUP)   strb_cnt <= WR_LOAD;
        else if (state == RD_SETUP)   strb_cnt <= RD_LOAD;
        else if (strb_cnt != '0)      strb_cnt <= strb_cnt - 1'b1;
    end

    // Occupancy after this cycle; accesses are serialised so inc and dec never coincide.
    always_comb begin
        count_nxt = count;
        if (inc)      count_nxt = count + 1'b1;
        else if (dec) count_nxt = count - 1'b1;
    end

    // Pointers, captured address/data, arbitration history and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            wdat         <= '0;
            rd_data_q    <= '0;
            sram_addr    <= '0;
            last_wr      <= 1'b0;
            count        <= '0;
            nfull        <= 1'b1;
            nempty       <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (accept_wr) begin
                wdat      <= bus.wr_data;
                sram_addr <= wp;
                last_wr   <= 1'b1;
            end else if (accept_rd) begin
                sram_addr <= rp;
                last_wr   <= 1'b0;
            end
            if (state == RD_STROBE && strb_cnt == '0) rd_data_q <= sram_data;
            if (inc) wp <= wp + 1'b1;
            if (dec) rp <= rp + 1'b1;
            count        <= count_nxt;
            nfull        <= (count_nxt != DEPTH_C);
            nempty       <= (count_nxt != '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    // Sticky error flags; a new error on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (state == IDLE && bus.wr_req && count == DEPTH_C) overflow <= 1'b1;
            else if (clr_err)                                     overflow <= 1'b0;
            if (state == IDLE && bus.rd_req && count == '0)      underflow <= 1'b1;
            else if (clr_err)                                     underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with an 8-word SRAM model.
module tb_sram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_err = 1'b0;
    logic nfull, nempty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0] count;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic sram_rd_n, sram_wr_n;

    sram_fifo_ctrl_if #(.DATA_W(DW)) ifc ();

    sram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WR_CYC(2), .RD_CYC(2),
                     .AF_LVL(DEPTH-4), .AE_LVL(4)) dut (
        .clk(clk), .rst(rst), .bus(ifc), .clr_err(clr_err),
        .nfull(nfull), .nempty(nempty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_rd_n(sram_rd_n), .sram_wr_n(sram_wr_n)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    assign sram_data = (!sram_rd_n) ? mem[sram_addr] : {DW{1'bz}};
    always @(posedge clk) if (!sram_wr_n) mem[sram_addr] <= sram_data;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] sbq [$];
    int m_wp = 0, m_rp = 0, m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) chk("strobe_exclusive", {31'd0, (!sram_rd_n && !sram_wr_n)}, 32'd0);

    task automatic chk_status(input string tag);
        chk({tag, "_count"},  count, m_cnt);
        chk({tag, "_nfull"},  nfull, (m_cnt != DEPTH));
        chk({tag, "_nempty"}, nempty, (m_cnt != 0));
        chk({tag, "_af"},     almost_full, (m_cnt >= DEPTH-4));
        chk({tag, "_ae"},     almost_empty, (m_cnt <= 4));
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        logic got;
        int lows;
        got = 1'b0;
        ifc.wr_data = d;
        ifc.wr_req  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ifc.wr_ack) got = 1'b1;
        end
        ifc.wr_req = 1'b0;
        chk("wr_ack_seen", got, 1);
        if (got) begin
            chk("wr_addr", sram_addr, m_wp);
            sbq.push_back(d);
            lows = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (!sram_wr_n) lows++;
            end
            chk("wr_n_low_cycles", lows, 2);
            m_wp = (m_wp + 1) % DEPTH;
            m_cnt++;
            chk_status("after_wr");
        end
    endtask

    task automatic do_read();
        logic got;
        logic [DW-1:0] e;
        got = 1'b0;
        ifc.rd_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ifc.rd_valid) got = 1'b1;
        end
        ifc.rd_req = 1'b0;
        chk("rd_valid_seen", got, 1);
        if (got) begin
            e = (sbq.size() > 0) ? sbq.pop_front() : 'x;
            chk("rd_data", ifc.rd_data, e);
            chk("rd_addr", sram_addr, m_rp);
            @(negedge clk);
            m_rp = (m_rp + 1) % DEPTH;
            m_cnt--;
            chk_status("after_rd");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_wp = 0; m_rp = 0; m_cnt = 0;
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad, nr, ev;
        logic got, expect_w;
        logic [DW-1:0] e;
        ifc.wr_req = 1'b0; ifc.rd_req = 1'b0; ifc.wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst_wr_n", sram_wr_n, 1);
        chk("rst_rd_n", sram_rd_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wr_ack", ifc.wr_ack, 0);
        chk("rst_rd_valid", ifc.rd_valid, 0);
        chk("rst_rd_data", ifc.rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk_status("rst");

        // Reset in the middle of a write strobe
        ifc.wr_data = 8'hAA; ifc.wr_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ifc.wr_ack) got = 1'b1;
        end
        chk("midwr_ack", got, 1);
        @(negedge clk);
        chk("midwr_strobe_low", sram_wr_n, 0);
        ifc.wr_req = 1'b0;
        pulse_reset();
        chk("midwr_wr_n", sram_wr_n, 1);
        chk("midwr_count", count, 0);
        chk("midwr_nempty", nempty, 0);

        // Read on empty: no strobe, no rd_valid, underflow set then cleared
        ifc.rd_req = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!sram_rd_n || ifc.rd_valid) bad++;
        end
        ifc.rd_req = 1'b0;
        chk("empty_rd_no_access", bad, 0);
        chk("underflow_set", underflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("underflow_clr", underflow, 0);

        // Basic ordering
        do_write(8'h11); do_write(8'h22); do_write(8'h33);
        do_read(); do_read(); do_read();
        chk("basic_nempty", nempty, 0);

        // Fill to full and overflow
        for (int i = 0; i < DEPTH; i++) do_write(DW'(8'hC0 + i));
        ifc.wr_data = 8'hEE; ifc.wr_req = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.wr_ack) bad++;
        end
        ifc.wr_req = 1'b0;
        chk("full_no_ack", bad, 0);
        chk("overflow_set", overflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("overflow_clr", overflow, 0);
        for (int i = 0; i < DEPTH; i++) do_read();

        // Pointer wrap from a fresh reset: write addresses 6,7,0,1,2
        pulse_reset();
        for (int i = 0; i < 6; i++) do_write(DW'(8'h40 + i));
        for (int i = 0; i < 6; i++) do_read();
        for (int i = 0; i < 5; i++) do_write(DW'(8'h50 + i));
        do_read(); do_read(); do_read();

        // Both requests held with count=2: alternate W,R,... starting with W
        ifc.wr_data = 8'hA0;
        ifc.wr_req = 1'b1; ifc.rd_req = 1'b1;
        expect_w = 1'b1; nr = 0; ev = 0;
        for (int i = 0; i < 200 && nr < 4; i++) begin
            @(negedge clk);
            if (ifc.wr_ack) begin
                chk("alt_order_w", expect_w, 1);
                chk("alt_count_w", count, 2);
                sbq.push_back(ifc.wr_data);
                ifc.wr_data = ifc.wr_data + 1'b1;
                expect_w = 1'b0;
                ev++;
            end
            if (ifc.rd_valid) begin
                chk("alt_order_r", expect_w, 0);
                chk("alt_count_r", count, 3);
                e = (sbq.size() > 0) ? sbq.pop_front() : 'x;
                chk("alt_rd_data", ifc.rd_data, e);
                expect_w = 1'b1;
                nr++;
                ev++;
                if (nr == 4) begin
                    ifc.wr_req = 1'b0; ifc.rd_req = 1'b0;
                end
            end
        end
        ifc.wr_req = 1'b0; ifc.rd_req = 1'b0;
        chk("alt_events", ev, 8);
        @(negedge clk);
        m_wp = (m_wp + 4) % DEPTH;
        m_rp = (m_rp + 4) % DEPTH;
        chk_status("alt_end");
        do_read(); do_read();
        chk("final_nempty", nempty, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Parametrised FIFO controller that uses an external asynchronous single-port SRAM as FIFO storage, with programmable data width and depth. The user side has level-request/ack handshakes. The SRAM side is a multi-cycle strobe sequencer with configurable strobe length. Compared with the earlier 8-bit SRAM FIFO front end, it adds fair read/write arbitration, almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow flags.

Parameters:
DATA_W, 8, user and SRAM data width
ADDR_W, 11, SRAM address width; DEPTH = 2**ADDR_W words
WR_CYC, 2, cycles sram_wr_n held low (>=1)
RD_CYC, 2, cycles sram_rd_n held low before sampling (>=1)
AF_LVL, DEPTH-4, almost_full asserted when count >= AF_LVL
AE_LVL, 4, almost_empty asserted when count <= AE_LVL

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_req  in  1  write request, held with wr_data until wr_ack
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse: write accepted
rd_req  in  1  read request, held until rd_valid
rd_data  out  DATA_W  read data, stable from rd_valid until next read completes
rd_valid  out  1  one-cycle pulse: rd_data valid
clr_err  in  1  clears overflow/underflow
nfull  out  1  count != DEPTH
nempty  out  1  count != 0
almost_full  out  1  see AF_LVL
almost_empty  out  1  see AE_LVL
count  out  ADDR_W+1  stored words, 0..DEPTH
overflow  out  1  sticky
underflow  out  1  sticky
sram_addr  out  ADDR_W  SRAM address
sram_data  inout  DATA_W  SRAM bidirectional data bus
sram_rd_n  out  1  SRAM output enable, active low
sram_wr_n  out  1  SRAM write enable, active low

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; wp=rp=count=0; sram_rd_n=sram_wr_n=1; sram_data hi-Z; sram_addr=0; wr_ack=rd_valid=0; rd_data=0; overflow=underflow=0; nfull=1, nempty=0, almost_empty=1, almost_full=0. Any in-flight access is abandoned and its data discarded.
- All status outputs are registered and consistent with count in the same cycle.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, RD_HOLD.
- IDLE, acceptance rules:
  - A write is eligible when wr_req=1 and nfull.
  - A read is eligible when rd_req=1 and nempty.
  - If both are eligible, the type not served last wins (round-robin). The last-served bit resets to "read", so a write wins the first tie.
  - Winner write -> WR_SETUP, capturing wr_data. Winner read -> RD_SETUP.
- Write sequence:
  - WR_SETUP: 1 cycle, wr_ack=1, sram_addr=wp, bus driven, wr_n=1.
  - WR_STROBE: WR_CYC cycles, wr_n=0, addr/data held.
  - WR_HOLD: 1 cycle, wr_n=1, addr/data still driven.
  - Then IDLE, with wp+1 (wraps DEPTH-1 -> 0) and count+1.
- Read sequence:
  - RD_SETUP: 1 cycle, sram_addr=rp, bus hi-Z, rd_n=0.
  - RD_STROBE: RD_CYC cycles, rd_n=0; rd_data samples sram_data on the final RD_STROBE edge.
  - RD_HOLD: 1 cycle, rd_n=1, rd_valid=1.
  - Then IDLE, with rp+1 (wrap) and count-1.
- sram_rd_n and sram_wr_n are never low simultaneously. The bus is driven only in the WR_* states.
- Latency (from accept edge, WR_CYC=RD_CYC=2):
  - wr_ack at cycle +1; count updates at +5.
  - rd_valid at +4; count updates at +5.
- Since accesses are serialised, count never sees simultaneous increment and decrement.
- Error flags:
  - overflow sets when in IDLE with wr_req=1 and count==DEPTH.
  - underflow sets when in IDLE with rd_req=1 and count==0.
  - Both clear only on rst or clr_err=1; a set on the same edge as clr_err wins.
- Requests deasserted before acceptance are simply not served. Requests seen outside IDLE are ignored until return to IDLE.

Test Plan:
- Reset mid-write (rst during WR_STROBE) -> next cycle wr_n=1, bus hi-Z, count=0, nempty=0; a subsequent read request is not accepted.
- Write 0x11,0x22,0x33 then read 3 (DATA_W=8) -> rd_data 0x11,0x22,0x33 in order; wr_n low exactly 2 cycles per write; count 3 -> 0; final nempty=0.
- Fill with ADDR_W=3: 8 writes -> count=8, nfull=0, almost_full=1 at count>=4; 9th wr_req held -> no wr_ack, overflow=1; clr_err -> overflow=0.
- Pointer wrap (ADDR_W=3): 6 writes, 6 reads, 5 writes -> sram_addr sequence 6,7,0,1,2 on writes; data reads back correctly.
- wr_req and rd_req held high together with count=2 -> accesses alternate W,R,W,R… starting with W; count oscillates between 3 and 2.
- Read on empty FIFO -> no SRAM strobe, rd_valid stays 0, underflow=1.
